nios2_mem_loader: RTL and testbench

Boot-image loader sitting directly upstream of the Nios II on-chip memory's s1 slave port. It accepts a byte stream (Avalon-ST, 8-bit), packs the bytes little-endian into 32-bit words, and writes them to a contiguous word range of the 5120×32 single-port RAM. It then reads the range back, compares a 32-bit additive checksum, and reports pass/fail. The CPU is held off the memory port while `busy` is high; arbitration is outside this block.

---
 rtl/nios2_mem_loader_pkg.sv | 18 +
 rtl/nios2_mem_loader_if.sv | 39 +++
 rtl/nios2_mem_loader_packer.sv | 42 ++++
 rtl/nios2_mem_loader.sv | 167 ++++++++++++++++
 tb/tb_nios2_mem_loader.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/nios2_mem_loader_pkg.sv
// Shared types and memory geometry for the Nios II boot-image loader.
package nios2_mem_pkg;

    localparam int MEM_DEPTH  = 5120;
    localparam int MEM_ADDR_W = 13;
    localparam int MEM_DATA_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WRITE,
        ST_VADDR,
        ST_VDATA,
        ST_CHECK,
        ST_DONE
    } state_t;

endpackage

// File: rtl/nios2_mem_loader_if.sv
// Control, byte-stream and on-chip-memory signals of the boot-image loader.
// The master modport is the loader side; slave is the surrounding system.
interface nios2_mem_loader_if
    import nios2_mem_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W
) ();

    logic                  start;
    logic [ADDR_W-1:0]     base_addr;
    logic [ADDR_W:0]       word_count;
    logic [7:0]            st_data;
    logic                  st_valid;
    logic                  st_ready;
    logic [ADDR_W-1:0]     mem_address;
    logic [3:0]            mem_byteenable;
    logic                  mem_chipselect;
    logic                  mem_write;
    logic [MEM_DATA_W-1:0] mem_writedata;
    logic                  mem_clken;
    logic [MEM_DATA_W-1:0] mem_readdata;
    logic                  busy;
    logic                  done;
    logic                  error;
    logic [MEM_DATA_W-1:0] checksum;

    modport master (
        input  start, base_addr, word_count, st_data, st_valid, mem_readdata,
        output st_ready, mem_address, mem_byteenable, mem_chipselect, mem_write,
               mem_writedata, mem_clken, busy, done, error, checksum
    );

    modport slave (
        output start, base_addr, word_count, st_data, st_valid, mem_readdata,
        input  st_ready, mem_address, mem_byteenable, mem_chipselect, mem_write,
               mem_writedata, mem_clken, busy, done, error, checksum
    );

endinterface

// File: rtl/nios2_mem_loader_packer.sv
// Little-endian byte packer: the first byte of a word ends up in bits 7:0.
module nios2_byte_packer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear_i,
    input  logic        accept_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_valid_o
);

    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [31:0] word_q, word_d;

    // Shift each byte in from the top so four shifts leave lane 0 holding the oldest byte.
    always_comb begin
        byte_idx_d = byte_idx_q;
        word_d     = word_q;
        if (clear_i) begin
            byte_idx_d = 2'd0;
            word_d     = 32'd0;
        end else if (accept_i) begin
            byte_idx_d = byte_idx_q + 2'd1;
            word_d     = {byte_i, word_q[31:8]};
        end
    end

    // Packer registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            byte_idx_q <= 2'd0;
            word_q     <= 32'd0;
        end else begin
            byte_idx_q <= byte_idx_d;
            word_q     <= word_d;
        end
    end

    assign word_o       = word_q;
    assign word_valid_o = accept_i && (byte_idx_q == 2'd3);

endmodule

// File: rtl/nios2_mem_loader.sv
// Boot-image loader: packs a byte stream into words, writes them to on-chip RAM,
// reads the range back and compares additive checksums.
//
//   state    | meaning
//   ---------+---------------------------------------------------
//   ST_IDLE  | waiting for start; busy low
//   ST_LOAD  | accepting stream bytes into the packer
//   ST_WRITE | writing the packed word, accumulating checksum
//   ST_VADDR | presenting a read address
//   ST_VDATA | accumulating read data into the verify sum
//   ST_CHECK | comparing verify sum against written checksum
//   ST_DONE  | one-cycle done pulse
module nios2_mem_loader
    import nios2_mem_pkg::*;
#(
    parameter int DEPTH  = MEM_DEPTH,
    parameter int ADDR_W = MEM_ADDR_W
) (
    input  logic                   clk,
    input  logic                   reset_n,
    nios2_mem_loader_if.master     bus
);

    localparam logic [ADDR_W:0]   IDX_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    state_t                state_q, state_d;
    logic [ADDR_W-1:0]     base_q, base_d;
    logic [ADDR_W:0]       count_q, count_d;
    logic [ADDR_W:0]       word_idx_q, word_idx_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [MEM_DATA_W-1:0] checksum_q, checksum_d;
    logic [MEM_DATA_W-1:0] verify_q, verify_d;
    logic                  error_q, error_d;

    logic                  start_ok;
    logic                  accept;
    logic                  word_valid;
    logic [31:0]           packed_word;
    logic [ADDR_W:0]       word_idx_inc;
    logic                  last_word;
    logic [ADDR_W+1:0]     end_addr;
    logic                  range_bad;

    assign start_ok     = (state_q == ST_IDLE) && bus.start;
    assign accept       = (state_q == ST_LOAD) && bus.st_valid;
    assign word_idx_inc = word_idx_q + IDX_ONE;
    assign last_word    = (word_idx_inc == count_q);
    // Two extra bits so base + count cannot overflow before the depth compare.
    assign end_addr     = {2'b00, bus.base_addr} + {1'b0, bus.word_count};
    assign range_bad    = end_addr > (ADDR_W+2)'(DEPTH);

    nios2_byte_packer u_packer (
        .clk          (clk),
        .reset_n      (reset_n),
        .clear_i      (start_ok),
        .accept_i     (accept),
        .byte_i       (bus.st_data),
        .word_o       (packed_word),
        .word_valid_o (word_valid)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    if (bus.word_count == '0 || range_bad) state_d = ST_DONE;
                    else                                   state_d = ST_LOAD;
                end
            end
            ST_LOAD:  if (word_valid) state_d = ST_WRITE;
            ST_WRITE: state_d = last_word ? ST_VADDR : ST_LOAD;
            ST_VADDR: state_d = ST_VDATA;
            ST_VDATA: state_d = last_word ? ST_CHECK : ST_VADDR;
            ST_CHECK: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Strobes decoded from the state register only.
    always_comb begin
        bus.st_ready       = (state_q == ST_LOAD);
        bus.mem_chipselect = (state_q == ST_WRITE) || (state_q == ST_VADDR);
        bus.mem_write      = (state_q == ST_WRITE);
        bus.busy           = (state_q != ST_IDLE);
        bus.done           = (state_q == ST_DONE);
    end

    // Address counter, word counter and both checksums.
    always_comb begin
        base_d     = base_q;
        count_d    = count_q;
        word_idx_d = word_idx_q;
        addr_d     = addr_q;
        checksum_d = checksum_q;
        verify_d   = verify_q;
        error_d    = error_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    base_d     = bus.base_addr;
                    count_d    = bus.word_count;
                    word_idx_d = '0;
                    addr_d     = bus.base_addr;
                    checksum_d = '0;
                    verify_d   = '0;
                    error_d    = (bus.word_count != '0) && range_bad;
                end
            end
            ST_WRITE: begin
                checksum_d = checksum_q + packed_word;
                if (last_word) begin
                    word_idx_d = '0;
                    addr_d     = base_q;
                end else begin
                    word_idx_d = word_idx_inc;
                    addr_d     = addr_q + ADDR_ONE;
                end
            end
            ST_VDATA: begin
                verify_d   = verify_q + bus.mem_readdata;
                word_idx_d = word_idx_inc;
                addr_d     = addr_q + ADDR_ONE;
            end
            ST_CHECK: error_d = (verify_q != checksum_q);
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            base_q     <= '0;
            count_q    <= '0;
            word_idx_q <= '0;
            addr_q     <= '0;
            checksum_q <= '0;
            verify_q   <= '0;
            error_q    <= 1'b0;
        end else begin
            base_q     <= base_d;
            count_q    <= count_d;
            word_idx_q <= word_idx_d;
            addr_q     <= addr_d;
            checksum_q <= checksum_d;
            verify_q   <= verify_d;
            error_q    <= error_d;
        end
    end

    assign bus.mem_address    = addr_q;
    assign bus.mem_writedata  = packed_word;
    assign bus.mem_byteenable = 4'hF;
    assign bus.mem_clken      = 1'b1;
    assign bus.error          = error_q;
    assign bus.checksum       = checksum_q;

endmodule

// File: tb/tb_nios2_mem_loader.sv
// Directed and randomized bench for the boot-image loader with a RAM model.
module tb_nios2_mem_loader;
    import nios2_mem_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    nios2_mem_loader_if #(.ADDR_W(MEM_ADDR_W)) bus ();

    nios2_mem_loader #(.DEPTH(MEM_DEPTH), .ADDR_W(MEM_ADDR_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // RAM model: registered address, one cycle read latency, optional corruption on readback.
    logic [31:0] ram [0:8191];
    logic [31:0] rd_q;
    logic        corrupt_on = 1'b0;
    logic [12:0] corrupt_addr = '0;
    always @(posedge clk) begin
        if (bus.mem_chipselect && bus.mem_write) ram[bus.mem_address] <= bus.mem_writedata;
        rd_q <= ram[bus.mem_address] ^
                ((corrupt_on && bus.mem_address == corrupt_addr) ? 32'h0001_0000 : 32'h0);
    end
    assign bus.mem_readdata = rd_q;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input int base, input int cnt, input int gap, input int corrupt_idx,
                          input bit seq_bytes, input string tag);
        logic [7:0]  bytes_q[$];
        logic [31:0] exp_words[$];
        logic [31:0] obs_data[$];
        int          obs_addr[$];
        logic [31:0] exp_sum;
        logic [31:0] w;
        bit          range_bad, active, exp_err, got_done, acc;
        int          nbytes, bi, idle, edges, cs_cnt, rdy_cnt, wr_rdy, const_bad, exp_lat, limit, nw;

        exp_sum = '0; bi = 0; idle = 0; edges = 0; cs_cnt = 0; rdy_cnt = 0; wr_rdy = 0;
        const_bad = 0; got_done = 1'b0; acc = 1'b0;
        range_bad = (base + cnt) > MEM_DEPTH;
        active    = (cnt > 0) && !range_bad;
        nbytes    = active ? cnt * 4 : 4;
        for (int i = 0; i < nbytes; i++)
            bytes_q.push_back(seq_bytes ? 8'(i + 1) : 8'($urandom_range(0, 255)));
        if (active) begin
            for (int k = 0; k < cnt; k++) begin
                w = {bytes_q[4*k+3], bytes_q[4*k+2], bytes_q[4*k+1], bytes_q[4*k]};
                exp_words.push_back(w);
                exp_sum += w;
            end
        end
        exp_err = active ? (corrupt_idx >= 0 && corrupt_idx < cnt) : (cnt > 0);
        // Cycles from start to done inclusive of the start cycle: 1 + 5N + 2N + 1 + 1.
        exp_lat = active ? (1 + 5*cnt + 2*cnt + 1 + 1) - 1 : 1;
        limit   = 10 * (cnt + 1) * gap + 20;
        corrupt_on   = (corrupt_idx >= 0);
        corrupt_addr = 13'(base + (corrupt_idx >= 0 ? corrupt_idx : 0));

        @(negedge clk);
        chk({tag, "_busy_idle"}, 32'(bus.busy), 32'd0);
        bus.start      = 1'b1;
        bus.base_addr  = 13'(base);
        bus.word_count = 14'(cnt);
        bus.st_valid   = 1'b1;
        bus.st_data    = bytes_q[0];
        acc = bus.st_valid && bus.st_ready;

        while (!got_done && edges < limit) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            bus.start = 1'b0;
            if (edges == 1) chk({tag, "_busy_rise"}, 32'(bus.busy), 32'd1);
            if (bus.mem_chipselect) cs_cnt++;
            if (bus.mem_chipselect && bus.mem_write) begin
                obs_addr.push_back(int'(bus.mem_address));
                obs_data.push_back(bus.mem_writedata);
                if (bus.st_ready) wr_rdy++;
            end
            if (bus.st_ready) rdy_cnt++;
            if (bus.mem_byteenable !== 4'hF || bus.mem_clken !== 1'b1) const_bad++;
            if (bus.done) got_done = 1'b1;
            if (acc) begin
                bi++;
                idle = gap - 1;
                bus.st_valid = 1'b0;
            end
            if (!bus.st_valid && bi < nbytes) begin
                if (idle == 0) begin
                    bus.st_valid = 1'b1;
                    bus.st_data  = bytes_q[bi];
                end else idle--;
            end
            acc = bus.st_valid && bus.st_ready;
        end
        bus.st_valid = 1'b0;

        chk({tag, "_done_seen"}, 32'(got_done), 32'd1);
        if (gap == 1 || !active) chk({tag, "_latency"}, 32'(edges), 32'(exp_lat));
        chk({tag, "_error"}, 32'(bus.error), 32'(exp_err));
        chk({tag, "_checksum"}, bus.checksum, exp_sum);
        chk({tag, "_n_writes"}, 32'(obs_data.size()), 32'(exp_words.size()));
        nw = (obs_data.size() < exp_words.size()) ? obs_data.size() : exp_words.size();
        for (int k = 0; k < nw; k++) begin
            chk($sformatf("%s_wdata%0d", tag, k), obs_data[k], exp_words[k]);
            chk($sformatf("%s_waddr%0d", tag, k), 32'(obs_addr[k]), 32'(base + k));
        end
        chk({tag, "_n_access"}, 32'(cs_cnt), 32'(active ? 2 * cnt : 0));
        chk({tag, "_bytes_taken"}, 32'(active ? bi : bi + 4), 32'(active ? nbytes : 4));
        chk({tag, "_ready_in_write"}, 32'(wr_rdy), 32'd0);
        chk({tag, "_const_outs"}, 32'(const_bad), 32'd0);
        if (!active) chk({tag, "_ready_never"}, 32'(rdy_cnt), 32'd0);

        @(posedge clk);
        @(negedge clk);
        chk({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
        chk({tag, "_busy_after"}, 32'(bus.busy), 32'd0);
        chk({tag, "_error_sticky"}, 32'(bus.error), 32'(exp_err));
        corrupt_on = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_st_ready"}, 32'(bus.st_ready), 32'd0);
        chk({tag, "_cs"}, 32'(bus.mem_chipselect), 32'd0);
        chk({tag, "_write"}, 32'(bus.mem_write), 32'd0);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_done"}, 32'(bus.done), 32'd0);
        chk({tag, "_error"}, 32'(bus.error), 32'd0);
        chk({tag, "_addr"}, 32'(bus.mem_address), 32'd0);
        chk({tag, "_wdata"}, bus.mem_writedata, 32'd0);
        chk({tag, "_checksum"}, bus.checksum, 32'd0);
        chk({tag, "_be"}, 32'(bus.mem_byteenable), 32'hF);
        chk({tag, "_clken"}, 32'(bus.mem_clken), 32'd1);
    endtask

    initial begin
        int base, cnt, gap, cidx;

        bus.start = 1'b0; bus.base_addr = '0; bus.word_count = '0;
        bus.st_data = '0; bus.st_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("por");
        reset_n = 1'b1;

        run_op(0, 2, 1, -1, 1'b1, "seq2");
        chk("seq2_checksum_const", bus.checksum, 32'h0C0A_0806);
        run_op(5119, 2, 1, -1, 1'b0, "range_err");
        run_op(int'($urandom_range(0, 8191)), 0, 1, -1, 1'b0, "zero_cnt");
        run_op(int'($urandom_range(0, 5119)), 1, 3, -1, 1'b0, "gapped");
        run_op(int'($urandom_range(0, 5000)), 3, 1, 1, 1'b0, "corrupt");
        run_op(5118, 2, 1, -1, 1'b0, "top_fit");
        run_op(5119, 1, 2, -1, 1'b0, "last_word");

        // Reset after the second byte of word 0.
        base = int'($urandom_range(0, 5119));
        @(negedge clk);
        bus.start = 1'b1; bus.base_addr = 13'(base); bus.word_count = 14'd1;
        bus.st_valid = 1'b1; bus.st_data = 8'hAA;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.st_data = 8'hBB;
        @(posedge clk);
        @(negedge clk);
        bus.st_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        @(negedge clk);
        reset_n = 1'b1;
        run_op(base, 1, 1, -1, 1'b0, "post_reset");

        for (int r = 0; r < 4; r++) begin
            cnt  = int'($urandom_range(1, 8));
            base = int'($urandom_range(0, MEM_DEPTH - cnt));
            gap  = int'($urandom_range(1, 3));
            cidx = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, cnt - 1)) : -1;
            run_op(base, cnt, gap, cidx, 1'b0, $sformatf("rand%0d", r));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
